// File: rtl/uart_tx_core_if.sv
// Byte-producer side of the UART transmitter.
// Producer (master) drives the byte, the enable and the frame configuration.
// The core (slave) returns the serial line, busy and the data-sent pulse.
interface uart_tx_core_if;
    logic       enable_i;     // start or continue frames while high
    logic [7:0] data_i;       // byte to send, sampled at frame start
    logic       parity_en_i;  // 1 = include a parity bit
    logic       parity_sel_i; // 1 = odd parity, 0 = even parity
    logic       stop_sel_i;   // 0 = one stop bit, 1 = two stop bits
    logic       data_o;       // serial line, idles high
    logic       busy_o;       // high while a frame is on the line
    logic       data_sent_o;  // one-cycle pulse when the last data bit finishes

    modport master (
        output enable_i, data_i, parity_en_i, parity_sel_i, stop_sel_i,
        input  data_o, busy_o, data_sent_o
    );

    modport slave (
        input  enable_i, data_i, parity_en_i, parity_sel_i, stop_sel_i,
        output data_o, busy_o, data_sent_o
    );
endinterface

// File: rtl/uart_tx_core.sv
// UART serializer: start bit, 8 data bits LSB first, optional parity, one or
// two stop bits. Each bit lasts DIV = p_clk_speed_hz / p_baud_rate clocks.
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   bus      uart_tx_core_if.slave (enable/data/config in; line/busy/sent out)
module uart_tx_core #(
    parameter int unsigned p_clk_speed_hz = 50_000_000,
    parameter int unsigned p_baud_rate    = 115_200
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    uart_tx_core_if.slave   bus
);

    localparam int unsigned DIV   = p_clk_speed_hz / p_baud_rate;
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_core: clock divider must be at least 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_n;
    logic [2:0]       bit_cnt, bit_cnt_n;
    logic [7:0]       shift, shift_n;
    logic             par_en, par_en_n;
    logic             par_bit, par_bit_n;
    logic             two_stop, two_stop_n;
    logic             line, line_n;
    logic             busy, busy_n;
    logic             sent, sent_n;

    logic             baud_end;
    logic             frame_end;
    logic             load;

    // Next-state and next-output logic; outputs are registered below.
    always_comb begin
        state_n    = state;
        baud_cnt_n = baud_cnt;
        bit_cnt_n  = bit_cnt;
        shift_n    = shift;
        par_en_n   = par_en;
        par_bit_n  = par_bit;
        two_stop_n = two_stop;
        line_n     = line;
        busy_n     = busy;
        sent_n     = 1'b0;
        frame_end  = 1'b0;
        load       = 1'b0;

        baud_end   = (baud_cnt == BAUD_LAST);
        if (state != S_IDLE) begin
            baud_cnt_n = baud_end ? '0 : baud_cnt + CNT_W'(1);
        end

        case (state)
            S_IDLE: begin
                baud_cnt_n = '0;
                line_n     = 1'b1;
                busy_n     = 1'b0;
                load       = bus.enable_i;
            end
            S_START: begin
                if (baud_end) begin
                    state_n   = S_DATA;
                    line_n    = shift[0];
                    shift_n   = shift >> 1;
                    bit_cnt_n = '0;
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_cnt == 3'd7) begin
                        sent_n    = 1'b1;
                        bit_cnt_n = '0;
                        if (par_en) begin
                            state_n = S_PARITY;
                            line_n  = par_bit;
                        end else begin
                            state_n = S_STOP1;
                            line_n  = 1'b1;
                        end
                    end else begin
                        line_n    = shift[0];
                        shift_n   = shift >> 1;
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_n = S_STOP1;
                    line_n  = 1'b1;
                end
            end
            S_STOP1: begin
                if (baud_end) begin
                    if (two_stop) begin
                        state_n = S_STOP2;
                        line_n  = 1'b1;
                    end else begin
                        frame_end = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                frame_end = baud_end;
            end
            default: begin
                state_n = S_IDLE;
                line_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase

        // Back-to-back frames skip IDLE so the line never shows a gap.
        if (frame_end) begin
            if (bus.enable_i) begin
                load = 1'b1;
            end else begin
                state_n    = S_IDLE;
                line_n     = 1'b1;
                busy_n     = 1'b0;
                baud_cnt_n = '0;
            end
        end

        // Frame-start latch: all inputs are captured only here.
        if (load) begin
            state_n    = S_START;
            shift_n    = bus.data_i;
            par_en_n   = bus.parity_en_i;
            par_bit_n  = bus.parity_sel_i ? ~^bus.data_i : ^bus.data_i;
            two_stop_n = bus.stop_sel_i;
            line_n     = 1'b0;
            busy_n     = 1'b1;
            baud_cnt_n = '0;
            bit_cnt_n  = '0;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            two_stop <= 1'b0;
            line     <= 1'b1;
            busy     <= 1'b0;
            sent     <= 1'b0;
        end else begin
            state    <= state_n;
            baud_cnt <= baud_cnt_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            par_en   <= par_en_n;
            par_bit  <= par_bit_n;
            two_stop <= two_stop_n;
            line     <= line_n;
            busy     <= busy_n;
            sent     <= sent_n;
        end
    end

    assign bus.data_o      = line;
    assign bus.busy_o      = busy;
    assign bus.data_sent_o = sent;

endmodule

// File: tb/tb_uart_tx_core.sv
// Directed bench for uart_tx_core with DIV = 40 / 10 = 4 clocks per bit.
module tb_uart_tx_core;

    localparam int DIV = 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    uart_tx_core_if u_if ();

    uart_tx_core #(
        .p_clk_speed_hz(40),
        .p_baud_rate   (10)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [7:0] d, input logic pen, input logic psel,
                              input logic ssel, input logic en);
        u_if.data_i       = d;
        u_if.parity_en_i  = pen;
        u_if.parity_sel_i = psel;
        u_if.stop_sel_i   = ssel;
        u_if.enable_i     = en;
    endtask

    // Expected line sequence for one frame, one entry per bit time.
    task automatic make_frame(input logic [7:0] d, input logic pen, input logic psel,
                              input logic ssel, output logic [11:0] bits, output int n);
        int idx;
        bits    = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        idx = 9;
        if (pen) begin
            bits[idx] = psel ? ~^d : ^d;
            idx++;
        end
        bits[idx] = 1'b1;
        idx++;
        if (ssel) begin
            bits[idx] = 1'b1;
            idx++;
        end
        n = idx;
    endtask

    // Checks every cycle of one frame starting at the next edge; mid-bit
    // samples are decoded like a receiver would.
    task automatic check_frame(input logic [7:0] d, input logic pen, input logic psel,
                               input logic ssel, input logic drop_en);
        logic [11:0] bits;
        logic [11:0] rx;
        int          n;
        make_frame(d, pen, psel, ssel, bits, n);
        rx = '0;
        for (int b = 0; b < n; b++) begin
            for (int c = 0; c < DIV; c++) begin
                @(posedge clk);
                #1;
                chk($sformatf("line d=%02h b%0d c%0d", d, b, c), 8'(u_if.data_o), 8'(bits[b]));
                chk($sformatf("busy d=%02h b%0d c%0d", d, b, c), 8'(u_if.busy_o), 8'd1);
                chk($sformatf("sent d=%02h b%0d c%0d", d, b, c), 8'(u_if.data_sent_o),
                    8'((b == 9) && (c == 0)));
                if (c == DIV / 2) rx[b] = u_if.data_o;
                if (drop_en && b == 0 && c == 0) begin
                    // Frame must ignore everything after its start latch.
                    set_inputs(~d, ~pen, ~psel, ~ssel, 1'b0);
                end
            end
        end
        chk($sformatf("rx byte %02h", d), rx[8:1], d);
        chk($sformatf("rx start %02h", d), 8'(rx[0]), 8'd0);
        if (pen) chk($sformatf("rx parity %02h", d), 8'(^rx[9:1] ^ psel), 8'd0);
        chk($sformatf("rx stop %02h", d), 8'(rx[n-1]), 8'd1);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("%s line %0d", tag, i), 8'(u_if.data_o), 8'd1);
            chk($sformatf("%s busy %0d", tag, i), 8'(u_if.busy_o), 8'd0);
            chk($sformatf("%s sent %0d", tag, i), 8'(u_if.data_sent_o), 8'd0);
        end
    endtask

    logic [7:0] msg [5];

    initial begin
        checks = 0;
        errors = 0;
        msg[0] = 8'h48; msg[1] = 8'h45; msg[2] = 8'h4C; msg[3] = 8'h4C; msg[4] = 8'h4F;

        // Reset values
        rst_n = 1'b0;
        set_inputs(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #12;
        chk("reset line", 8'(u_if.data_o), 8'd1);
        chk("reset busy", 8'(u_if.busy_o), 8'd0);
        chk("reset sent", 8'(u_if.data_sent_o), 8'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // enable low: line stays idle
        check_idle("idle_after_reset", 20);

        // 0x48 odd parity, one stop: 0|00010010|1|1; enable dropped mid-frame
        @(negedge clk);
        set_inputs(8'h48, 1'b1, 1'b1, 1'b0, 1'b1);
        check_frame(8'h48, 1'b1, 1'b1, 1'b0, 1'b1);
        check_idle("idle_after_odd", 6);

        // 0x48 even parity, two stops: parity 0, 12 bit times
        @(negedge clk);
        set_inputs(8'h48, 1'b1, 1'b0, 1'b1, 1'b1);
        check_frame(8'h48, 1'b1, 1'b0, 1'b1, 1'b1);
        check_idle("idle_after_even2", 6);

        // 0xFF, no parity, one stop: 0 then nine 1s
        @(negedge clk);
        set_inputs(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        check_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
        check_idle("idle_after_ff", 6);

        // "HELLO" back-to-back, odd parity, one stop, no idle gap
        @(negedge clk);
        set_inputs(msg[0], 1'b1, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check_frame(msg[i], 1'b1, 1'b1, 1'b0, (i == 4));
            if (i < 4) u_if.data_i = msg[i+1];
        end
        check_idle("idle_after_hello", 6);

        // Reset during DATA: line and busy drop asynchronously
        @(negedge clk);
        set_inputs(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (DIV + 2) @(posedge clk);
        #1;
        chk("pre_reset line bit0", 8'(u_if.data_o), 8'd0);
        chk("pre_reset busy", 8'(u_if.busy_o), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async reset line", 8'(u_if.data_o), 8'd1);
        chk("async reset busy", 8'(u_if.busy_o), 8'd0);
        chk("async reset sent", 8'(u_if.data_sent_o), 8'd0);
        @(negedge clk);
        set_inputs(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b1;
        check_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1);
        check_idle("idle_after_reset_frame", 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
